calc_core: RTL

Arithmetic and entry controller for the keypad calculator. Consumes the debounced `keycode`/`keypressed` pair from the keypad scanner, converts each new press into a single key event, accumulates decimal operands, and evaluates add/subtract/multiply with left-to-right chaining. Runs on the same divided 10 ms clock as the scanner. Its signed result and status outputs feed the seven-segment/LED display stage.

---
 rtl/calc_pkg.sv | 44 ++++
 rtl/key_edge_detect.sv | 23 ++
 rtl/calc_core.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared key codes, operator/state encodings and key classification helpers
// for the keypad calculator core.
package calc_pkg;

  localparam logic [3:0] KEY_ADD    = 4'hA;
  localparam logic [3:0] KEY_SUB    = 4'hB;
  localparam logic [3:0] KEY_MUL    = 4'hC;
  localparam logic [3:0] KEY_CLR    = 4'hD;
  localparam logic [3:0] KEY_EQ     = 4'hE;
  localparam logic [3:0] KEY_ALLCLR = 4'hF;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2,
    OP_MUL  = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    ENTRY_A = 3'd0,
    OP_WAIT = 3'd1,
    ENTRY_B = 3'd2,
    RESULT  = 3'd3,
    ERR     = 3'd4
  } state_t;

  function automatic logic is_digit(input logic [3:0] key);
    return (key <= 4'h9);
  endfunction

  function automatic logic is_oper(input logic [3:0] key);
    return (key == KEY_ADD) || (key == KEY_SUB) || (key == KEY_MUL);
  endfunction

  function automatic op_t key_to_op(input logic [3:0] key);
    case (key)
      KEY_ADD: return OP_ADD;
      KEY_SUB: return OP_SUB;
      KEY_MUL: return OP_MUL;
      default: return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Turns the level keypressed signal into a single-cycle press indication.
// prev_pressed resets high so a key held through reset is not seen as a press.
module key_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic keypressed,
  output logic key_event
);

  logic r_prev_pressed;

  // Previous-level register for rising-edge detection
  always_ff @(posedge clock) begin
    if (reset) begin
      r_prev_pressed <= 1'b1;
    end else begin
      r_prev_pressed <= keypressed;
    end
  end

  assign key_event = keypressed & ~r_prev_pressed;

endmodule

// File: rtl/calc_core.sv
// Keypad calculator entry FSM and datapath: decimal operand entry, add/sub/mul
// with left-to-right chaining, overflow detection and registered display outputs.
module calc_core
  import calc_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [3:0]              keycode,
  input  logic                    keypressed,
  output logic signed [WIDTH-1:0] display_value,
  output logic [1:0]              op,
  output logic [2:0]              state,
  output logic                    error,
  output logic                    key_event
);

  localparam int NDW = $clog2(MAX_DIGITS + 1);

  state_t             r_state, w_state_nx;
  op_t                r_op, w_op_nx;
  logic [WIDTH-1:0]   r_acc, w_acc_nx;
  logic [WIDTH-1:0]   r_opa, w_opa_nx;
  logic [NDW-1:0]     r_ndig, w_ndig_nx;
  logic [WIDTH-1:0]   r_disp, w_disp_nx;
  logic               r_error, r_key_event;
  logic               w_event;
  logic [WIDTH-1:0]   w_digit, w_append;
  logic               w_can_append;
  logic [2*WIDTH-1:0] w_a, w_b, w_res;
  logic               w_ovf;

  key_edge_detect u_edge (
    .clock      (clock),
    .reset      (reset),
    .keypressed (keypressed),
    .key_event  (w_event)
  );

  assign w_digit      = WIDTH'(keycode);
  assign w_append     = r_acc * WIDTH'(10) + w_digit;
  assign w_can_append = (r_ndig < NDW'(MAX_DIGITS));

  // Operands are sign-extended to 2*WIDTH so the full product fits exactly
  assign w_a = {{WIDTH{r_opa[WIDTH-1]}}, r_opa};
  assign w_b = {{WIDTH{r_acc[WIDTH-1]}}, r_acc};

  // Arithmetic result selection for the latched operator
  always_comb begin
    case (r_op)
      OP_ADD:  w_res = w_a + w_b;
      OP_SUB:  w_res = w_a - w_b;
      OP_MUL:  w_res = w_a * w_b;
      default: w_res = w_b;
    endcase
  end

  // In range only when the upper WIDTH+1 bits are all copies of the sign
  assign w_ovf = ~((&w_res[2*WIDTH-1:WIDTH-1]) | ~(|w_res[2*WIDTH-1:WIDTH-1]));

  // Next-state and datapath decode for one accepted key event
  always_comb begin
    w_state_nx = r_state;
    w_op_nx    = r_op;
    w_acc_nx   = r_acc;
    w_opa_nx   = r_opa;
    w_ndig_nx  = r_ndig;
    if (!w_event) begin
      w_state_nx = r_state;
    end else if (keycode == KEY_ALLCLR) begin
      w_state_nx = ENTRY_A;
      w_op_nx    = OP_NONE;
      w_acc_nx   = '0;
      w_opa_nx   = '0;
      w_ndig_nx  = '0;
    end else begin
      case (r_state)
        ENTRY_A, ENTRY_B: begin
          if (is_digit(keycode)) begin
            if (w_can_append) begin
              w_acc_nx  = w_append;
              w_ndig_nx = r_ndig + NDW'(1);
            end else begin
              w_acc_nx = r_acc;
            end
          end else if (keycode == KEY_CLR) begin
            w_acc_nx  = '0;
            w_ndig_nx = '0;
          end else if (r_state == ENTRY_A) begin
            if (is_oper(keycode)) begin
              w_opa_nx   = r_acc;
              w_op_nx    = key_to_op(keycode);
              w_state_nx = OP_WAIT;
            end else begin
              w_state_nx = r_state;
            end
          end else if (is_oper(keycode) || (keycode == KEY_EQ)) begin
            if (w_ovf) begin
              w_state_nx = ERR;
            end else begin
              w_opa_nx   = w_res[WIDTH-1:0];
              w_op_nx    = is_oper(keycode) ? key_to_op(keycode) : r_op;
              w_state_nx = is_oper(keycode) ? OP_WAIT : RESULT;
            end
          end else begin
            w_state_nx = r_state;
          end
        end
        OP_WAIT, RESULT: begin
          if (is_digit(keycode)) begin
            w_acc_nx   = w_digit;
            w_ndig_nx  = NDW'(1);
            w_op_nx    = (r_state == RESULT) ? OP_NONE : r_op;
            w_state_nx = (r_state == RESULT) ? ENTRY_A : ENTRY_B;
          end else if (is_oper(keycode)) begin
            w_op_nx    = key_to_op(keycode);
            w_state_nx = OP_WAIT;
          end else begin
            w_state_nx = r_state;
          end
        end
        default: w_state_nx = r_state;
      endcase
    end
  end

  // Display source follows the state being entered
  always_comb begin
    case (w_state_nx)
      ENTRY_A, ENTRY_B: w_disp_nx = w_acc_nx;
      OP_WAIT, RESULT:  w_disp_nx = w_opa_nx;
      default:          w_disp_nx = '0;
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ENTRY_A;
      r_op        <= OP_NONE;
      r_acc       <= '0;
      r_opa       <= '0;
      r_ndig      <= '0;
      r_disp      <= '0;
      r_error     <= 1'b0;
      r_key_event <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_op        <= w_op_nx;
      r_acc       <= w_acc_nx;
      r_opa       <= w_opa_nx;
      r_ndig      <= w_ndig_nx;
      r_disp      <= w_disp_nx;
      r_error     <= (w_state_nx == ERR);
      r_key_event <= w_event;
    end
  end

  assign display_value = r_disp;
  assign op            = r_op;
  assign state         = r_state;
  assign error         = r_error;
  assign key_event     = r_key_event;

endmodule
